// File: rtl/lap_stopwatch_if.sv
// Command/result bundle for lap_stopwatch.
//   cmd       : 00 clear, 01 hold, 10 run, 11 run+lap
//   count     : binary elapsed ticks
//   bcd       : BCD image of count, digit 0 (units) in bits [3:0]
//   lap       : last captured count
//   lap_valid : one-cycle pulse on each capture
//   tick      : one-cycle pulse when count shows a newly incremented value
//   sat       : high while count is at its saturation value
interface lap_stopwatch_if #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned DIGITS = 3
);
    logic [1:0]          cmd;
    logic [WIDTH-1:0]    count;
    logic [4*DIGITS-1:0] bcd;
    logic [WIDTH-1:0]    lap;
    logic                lap_valid;
    logic                tick;
    logic                sat;

    modport master (
        output cmd,
        input  count, bcd, lap, lap_valid, tick, sat
    );

    modport slave (
        input  cmd,
        output count, bcd, lap, lap_valid, tick, sat
    );
endinterface

// File: rtl/lap_stopwatch.sv
// Lap stopwatch: a prescaler divides clk_50M down to the tick rate, a binary
// counter and a cascaded BCD decade counter advance together and saturate at
// MAX_COUNT, and a rising edge into cmd 11 captures the current count.
//   clk_50M : single clock, rising edge
//   rst     : synchronous, active-high, overrides cmd
//   sw      : slave side of lap_stopwatch_if (cmd in, all results out, registered)
module lap_stopwatch #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned MAX_COUNT = 999,
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned DIGITS    = 3
) (
    input  logic           clk_50M,
    input  logic           rst,
    lap_stopwatch_if.slave sw
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW  = 4 * DIGITS;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_LAP   = 2'b11;

    // Elaboration-time parameter sanity.
    generate
        if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
            $error("lap_stopwatch: CLK_HZ/TICK_HZ must be an integer >= 2");
        end
        if (MAX_COUNT >= (64'd1 << WIDTH)) begin : g_bad_width
            $error("lap_stopwatch: MAX_COUNT does not fit in WIDTH bits");
        end
    endgenerate

    logic [PW-1:0]    presc_q,     presc_d;
    logic [WIDTH-1:0] count_q,     count_d;
    logic [BW-1:0]    bcd_q,       bcd_d;
    logic [BW-1:0]    bcd_inc;
    logic [WIDTH-1:0] lap_q,       lap_d;
    logic             lap_valid_q, lap_valid_d;
    logic             tick_q,      tick_d;
    logic             sat_q,       sat_d;
    logic [1:0]       cmd_q,       cmd_d;
    logic             wrap;
    logic             bcd_carry;

    // Decade cascade: each digit rolls 9 -> 0 and carries into the next.
    always_comb begin
        bcd_inc   = bcd_q;
        bcd_carry = 1'b1;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (bcd_carry) begin
                if (bcd_q[4*d +: 4] == 4'd9) begin
                    bcd_inc[4*d +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*d +: 4] = bcd_q[4*d +: 4] + 4'd1;
                    bcd_carry         = 1'b0;
                end
            end
        end
    end

    // Next-state for prescaler, counters, lap capture and cmd history.
    always_comb begin
        presc_d     = presc_q;
        count_d     = count_q;
        bcd_d       = bcd_q;
        lap_d       = lap_q;
        sat_d       = sat_q;
        tick_d      = 1'b0;
        lap_valid_d = 1'b0;
        cmd_d       = sw.cmd;
        wrap        = 1'b0;

        if (sw.cmd == CMD_CLEAR) begin
            presc_d = '0;
            count_d = '0;
            bcd_d   = '0;
            lap_d   = '0;
            sat_d   = 1'b0;
        end else begin
            // Prescaler only runs for 10/11 and parks at 0 once saturated.
            if (sw.cmd[1] && !sat_q) begin
                if (presc_q == PW'(DIV - 1)) begin
                    presc_d = '0;
                    wrap    = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            if (wrap) begin
                count_d = count_q + WIDTH'(1);
                bcd_d   = bcd_inc;
                tick_d  = 1'b1;
                sat_d   = (count_d == WIDTH'(MAX_COUNT));
            end

            // Capture on entry into 11; lap sees the pre-edge count.
            if (sw.cmd == CMD_LAP && cmd_q != CMD_LAP) begin
                lap_d       = count_q;
                lap_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            presc_q     <= '0;
            count_q     <= '0;
            bcd_q       <= '0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
            tick_q      <= 1'b0;
            sat_q       <= 1'b0;
            cmd_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            count_q     <= count_d;
            bcd_q       <= bcd_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
            tick_q      <= tick_d;
            sat_q       <= sat_d;
            cmd_q       <= cmd_d;
        end
    end

    assign sw.count     = count_q;
    assign sw.bcd       = bcd_q;
    assign sw.lap       = lap_q;
    assign sw.lap_valid = lap_valid_q;
    assign sw.tick      = tick_q;
    assign sw.sat       = sat_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch with DIV=10, MAX_COUNT=12, WIDTH=4, DIGITS=2.
module tb_lap_stopwatch;

    logic clk_50M = 1'b0;
    logic rst     = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    lap_stopwatch_if #(.WIDTH(4), .DIGITS(2)) sw ();

    lap_stopwatch #(
        .CLK_HZ   (10),
        .TICK_HZ  (1),
        .MAX_COUNT(12),
        .WIDTH    (4),
        .DIGITS   (2)
    ) dut (
        .clk_50M(clk_50M),
        .rst    (rst),
        .sw     (sw.slave)
    );

    always #5 clk_50M = ~clk_50M;

    // One clock edge; outputs are observed 1 time unit after it.
    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic run_cycles(input logic [1:0] c, input int n);
        sw.cmd = c;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        sw.cmd = 2'b11;
        step();
        vectors++; if (sw.count !== 4'd0)    begin miscompares++; $display("FAIL reset_count: got %0h want 0", sw.count); end
        vectors++; if (sw.bcd !== 8'h00)     begin miscompares++; $display("FAIL reset_bcd: got %0h want 0", sw.bcd); end
        vectors++; if (sw.lap !== 4'd0)      begin miscompares++; $display("FAIL reset_lap: got %0h want 0", sw.lap); end
        vectors++; if (sw.lap_valid !== 1'b0) begin miscompares++; $display("FAIL reset_lap_valid: got %b want 0", sw.lap_valid); end
        vectors++; if (sw.tick !== 1'b0)     begin miscompares++; $display("FAIL reset_tick: got %b want 0", sw.tick); end
        vectors++; if (sw.sat !== 1'b0)      begin miscompares++; $display("FAIL reset_sat: got %b want 0", sw.sat); end
        rst = 1'b0;
    endtask

    task automatic test_count();
        logic exp_tick;
        sw.cmd = 2'b10;
        for (int i = 1; i <= 30; i++) begin
            step();
            exp_tick = (i % 10 == 0);
            vectors++; if (sw.tick !== exp_tick) begin miscompares++; $display("FAIL count_tick@%0d: got %b want %b", i, sw.tick, exp_tick); end
        end
        vectors++; if (sw.count !== 4'd3)  begin miscompares++; $display("FAIL count_30: got %0d want 3", sw.count); end
        vectors++; if (sw.bcd !== 8'h03)   begin miscompares++; $display("FAIL bcd_30: got %0h want 03", sw.bcd); end
    endtask

    // Continues from count 3 with prescaler at 0.
    task automatic test_saturate();
        logic [3:0] exp_cnt;
        logic       exp_tick;
        sw.cmd = 2'b10;
        for (int i = 1; i <= 130; i++) begin
            step();
            exp_cnt  = (3 + i / 10 > 12) ? 4'd12 : 4'(3 + i / 10);
            exp_tick = (i % 10 == 0) && (i <= 90);
            vectors++; if (sw.count !== exp_cnt)  begin miscompares++; $display("FAIL sat_count@%0d: got %0d want %0d", i, sw.count, exp_cnt); end
            vectors++; if (sw.tick !== exp_tick)  begin miscompares++; $display("FAIL sat_tick@%0d: got %b want %b", i, sw.tick, exp_tick); end
            if (i == 70) begin
                vectors++; if (sw.bcd !== 8'h10) begin miscompares++; $display("FAIL bcd_carry_10: got %0h want 10", sw.bcd); end
            end
            if (i == 89) begin
                vectors++; if (sw.sat !== 1'b0) begin miscompares++; $display("FAIL sat_early: got %b want 0", sw.sat); end
            end
        end
        vectors++; if (sw.bcd !== 8'h12) begin miscompares++; $display("FAIL bcd_sat: got %0h want 12", sw.bcd); end
        vectors++; if (sw.sat !== 1'b1)  begin miscompares++; $display("FAIL sat_flag: got %b want 1", sw.sat); end
    endtask

    task automatic test_lap_while_sat();
        sw.cmd = 2'b11;
        step();
        vectors++; if (sw.lap !== 4'd12)      begin miscompares++; $display("FAIL satlap_lap: got %0d want 12", sw.lap); end
        vectors++; if (sw.lap_valid !== 1'b1) begin miscompares++; $display("FAIL satlap_valid: got %b want 1", sw.lap_valid); end
        vectors++; if (sw.count !== 4'd12)    begin miscompares++; $display("FAIL satlap_count: got %0d want 12", sw.count); end
        vectors++; if (sw.tick !== 1'b0)      begin miscompares++; $display("FAIL satlap_tick: got %b want 0", sw.tick); end
    endtask

    task automatic test_clear();
        sw.cmd = 2'b00;
        step();
        vectors++; if (sw.count !== 4'd0)     begin miscompares++; $display("FAIL clr_count: got %0d want 0", sw.count); end
        vectors++; if (sw.bcd !== 8'h00)      begin miscompares++; $display("FAIL clr_bcd: got %0h want 0", sw.bcd); end
        vectors++; if (sw.lap !== 4'd0)       begin miscompares++; $display("FAIL clr_lap: got %0d want 0", sw.lap); end
        vectors++; if (sw.lap_valid !== 1'b0) begin miscompares++; $display("FAIL clr_lap_valid: got %b want 0", sw.lap_valid); end
        vectors++; if (sw.sat !== 1'b0)       begin miscompares++; $display("FAIL clr_sat: got %b want 0", sw.sat); end
        vectors++; if (sw.tick !== 1'b0)      begin miscompares++; $display("FAIL clr_tick: got %b want 0", sw.tick); end
    endtask

    // Count 5 with prescaler at 3, hold 50, then only 7 more cycles to tick.
    task automatic test_hold();
        logic exp_tick;
        run_cycles(2'b10, 53);
        vectors++; if (sw.count !== 4'd5) begin miscompares++; $display("FAIL hold_pre: got %0d want 5", sw.count); end
        sw.cmd = 2'b01;
        for (int i = 1; i <= 50; i++) begin
            step();
            vectors++; if (sw.count !== 4'd5 || sw.tick !== 1'b0) begin miscompares++; $display("FAIL hold_frozen@%0d: count %0d tick %b want 5/0", i, sw.count, sw.tick); end
        end
        sw.cmd = 2'b10;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_tick = (i == 7);
            vectors++; if (sw.tick !== exp_tick) begin miscompares++; $display("FAIL hold_resume_tick@%0d: got %b want %b", i, sw.tick, exp_tick); end
        end
        vectors++; if (sw.count !== 4'd6) begin miscompares++; $display("FAIL hold_resume_count: got %0d want 6", sw.count); end
    endtask

    task automatic test_lap();
        int pulses;
        pulses = 0;
        test_clear();
        run_cycles(2'b10, 40);
        sw.cmd = 2'b11;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (sw.lap_valid === 1'b1) pulses++;
            if (i == 1) begin
                vectors++; if (sw.lap !== 4'd4 || sw.lap_valid !== 1'b1) begin miscompares++; $display("FAIL lap1: lap %0d valid %b want 4/1", sw.lap, sw.lap_valid); end
            end
        end
        vectors++; if (pulses != 1)        begin miscompares++; $display("FAIL lap_pulses: got %0d want 1", pulses); end
        vectors++; if (sw.count !== 4'd8)  begin miscompares++; $display("FAIL lap_count: got %0d want 8", sw.count); end
        vectors++; if (sw.lap !== 4'd4)    begin miscompares++; $display("FAIL lap_hold_value: got %0d want 4", sw.lap); end
        run_cycles(2'b10, 1);
        vectors++; if (sw.lap_valid !== 1'b0) begin miscompares++; $display("FAIL lap_drop: got %b want 0", sw.lap_valid); end
        run_cycles(2'b11, 1);
        vectors++; if (sw.lap !== 4'd8 || sw.lap_valid !== 1'b1) begin miscompares++; $display("FAIL lap2: lap %0d valid %b want 8/1", sw.lap, sw.lap_valid); end
    endtask

    task automatic test_same_edge();
        test_clear();
        run_cycles(2'b10, 69);
        vectors++; if (sw.count !== 4'd6 || sw.tick !== 1'b0) begin miscompares++; $display("FAIL edge_pre: count %0d tick %b want 6/0", sw.count, sw.tick); end
        run_cycles(2'b11, 1);
        vectors++; if (sw.lap !== 4'd6)       begin miscompares++; $display("FAIL edge_lap: got %0d want 6", sw.lap); end
        vectors++; if (sw.count !== 4'd7)     begin miscompares++; $display("FAIL edge_count: got %0d want 7", sw.count); end
        vectors++; if (sw.bcd !== 8'h07)      begin miscompares++; $display("FAIL edge_bcd: got %0h want 07", sw.bcd); end
        vectors++; if (sw.tick !== 1'b1)      begin miscompares++; $display("FAIL edge_tick: got %b want 1", sw.tick); end
        vectors++; if (sw.lap_valid !== 1'b1) begin miscompares++; $display("FAIL edge_lap_valid: got %b want 1", sw.lap_valid); end
    endtask

    task automatic test_rst_recover();
        logic exp_tick;
        test_clear();
        run_cycles(2'b10, 125);
        vectors++; if (sw.sat !== 1'b1) begin miscompares++; $display("FAIL rr_sat1: got %b want 1", sw.sat); end
        rst    = 1'b1;
        sw.cmd = 2'b11;
        step();
        vectors++; if (sw.count !== 4'd0 || sw.bcd !== 8'h00 || sw.lap !== 4'd0) begin miscompares++; $display("FAIL rr_rst_vals: count %0d bcd %0h lap %0d want 0", sw.count, sw.bcd, sw.lap); end
        vectors++; if (sw.sat !== 1'b0 || sw.tick !== 1'b0 || sw.lap_valid !== 1'b0) begin miscompares++; $display("FAIL rr_rst_flags: sat %b tick %b lv %b want 0", sw.sat, sw.tick, sw.lap_valid); end
        rst    = 1'b0;
        sw.cmd = 2'b10;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_tick = (i == 10);
            vectors++; if (sw.tick !== exp_tick) begin miscompares++; $display("FAIL rr_tick_a@%0d: got %b want %b", i, sw.tick, exp_tick); end
        end
        vectors++; if (sw.count !== 4'd1) begin miscompares++; $display("FAIL rr_count_a: got %0d want 1", sw.count); end
        run_cycles(2'b10, 115);
        vectors++; if (sw.sat !== 1'b1 || sw.count !== 4'd12) begin miscompares++; $display("FAIL rr_sat2: sat %b count %0d want 1/12", sw.sat, sw.count); end
        test_clear();
        sw.cmd = 2'b10;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_tick = (i == 10);
            vectors++; if (sw.tick !== exp_tick) begin miscompares++; $display("FAIL rr_tick_b@%0d: got %b want %b", i, sw.tick, exp_tick); end
        end
        vectors++; if (sw.count !== 4'd1) begin miscompares++; $display("FAIL rr_count_b: got %0d want 1", sw.count); end
    endtask

    initial begin
        sw.cmd = 2'b00;
        test_reset();
        test_count();
        test_saturate();
        test_lap_while_sat();
        test_clear();
        test_hold();
        test_lap();
        test_same_edge();
        test_rst_recover();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lap_stopwatch.md
LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 1000, count rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2, named DIV.
REQ-003 The block SHALL have parameter MAX_COUNT, default 999, saturation value of the count.
REQ-004 The block SHALL have parameter WIDTH, default 10, count width; MAX_COUNT SHALL be < 2^WIDTH.
REQ-005 The block SHALL have parameter DIGITS, default 3, BCD digit count; MAX_COUNT SHALL be < 10^DIGITS.
REQ-006 The block SHALL have port clk_50M, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-008 The block SHALL have port cmd, input, 2 bits: 00 clear, 01 hold, 10 run, 11 run+lap.
REQ-009 The block SHALL have port count, output, WIDTH bits, binary elapsed ticks.
REQ-010 The block SHALL have port bcd, output, 4*DIGITS bits, BCD of count, digit 0 (units) in bits [3:0].
REQ-011 The block SHALL have port lap, output, WIDTH bits, last captured count.
REQ-012 The block SHALL have port lap_valid, output, 1 bit, one-cycle pulse on each capture.
REQ-013 The block SHALL have port tick, output, 1 bit, one-cycle pulse in the cycle count shows a newly incremented value.
REQ-014 The block SHALL have port sat, output, 1 bit, high while count == MAX_COUNT.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 An internal prescaler SHALL count 0..DIV-1 on each cycle cmd is 10 or 11 and sat is 0; it wraps from DIV-1 to 0.
REQ-017 At the edge where the prescaler wraps, count SHALL increment by 1 and tick SHALL be 1 for the following cycle; count therefore advances exactly once per DIV running cycles.
REQ-018 bcd SHALL be maintained by a cascaded per-digit decade counter (9 -> 0 with carry), not by binary-to-BCD conversion, and SHALL equal count in every cycle.
REQ-019 cmd 01 SHALL freeze prescaler, count, bcd, sat, lap; tick and lap_valid 0.
REQ-020 cmd 00 SHALL, at the next edge, set prescaler, count, bcd, lap to 0 and sat, tick, lap_valid to 0.
REQ-021 Saturation: when count == MAX_COUNT, sat SHALL be 1, prescaler SHALL hold at 0, count/bcd SHALL not change, and tick SHALL stay 0 under run; only cmd 00 or rst leaves saturation.
REQ-022 Lap capture SHALL occur at an edge where cmd == 11 and the cmd sampled at the previous edge != 11; lap takes the pre-edge count value and lap_valid is 1 for the following cycle.
REQ-023 Holding cmd 11 SHALL capture once; a new capture requires cmd to leave 11 and return.
REQ-024 Capture and increment at the same edge: lap SHALL receive the pre-increment value, count the incremented value.
REQ-025 Capture while saturated SHALL occur normally (lap = MAX_COUNT).
REQ-026 Transitions between 10 and 11 SHALL not disturb prescaler phase.
REQ-027 The cmd-history register SHALL be set to 00 by reset and by cmd 00.

Reset
REQ-028 rst SHALL take priority over cmd at every edge.
REQ-029 On rst: prescaler, count, bcd, lap, cmd-history = 0; tick, lap_valid, sat = 0.
REQ-030 rst asserted mid-count or mid-capture SHALL discard the operation; counting resumes from 0 with a full DIV period after rst deasserts and cmd is run.

Verification (CLK_HZ=10, TICK_HZ=1 -> DIV=10, MAX_COUNT=12, WIDTH=4, DIGITS=2)
REQ-031 rst 1 cycle, cmd=10 for 30 cycles -> tick pulses on cycles 10, 20, 30 after run start; count 3; bcd 0x03.
REQ-032 cmd=10 for 130+ cycles -> count 12, bcd 0x12 (digit carry 9->10 seen at count 10), sat=1, no further tick.
REQ-033 Run to count 5, cmd=01 for 50 cycles, cmd=10 -> count stays 5 during hold; next tick arrives after the remaining prescaler cycles, not a full DIV.
REQ-034 Run to count 4, cmd=11 held 40 cycles -> single lap_valid pulse, lap=4, count keeps advancing to 8; drop to 10 and back to 11 -> second capture lap=8.
REQ-035 Enter cmd=11 at the exact edge of prescaler wrap with count 6 -> lap=6, count=7, tick and lap_valid both 1 the same cycle.
REQ-036 Saturated (count 12) then rst mid-run and cmd=00 separately -> all outputs 0 next cycle; first tick after run restarts occurs 10 cycles later.
